// File: rtl/uart_rx_deser_if.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_deser_if
// Brief    : Serial-in / parallel-out bundle between the link and the receiver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_deser_if #(
    parameter int MSG_WIDTH = 15
);
    logic                 enable_rx;
    logic                 msg_in_rx;
    logic [MSG_WIDTH-1:0] msg_out_rx;
    logic                 valid_rx;
    logic                 frame_err_rx;
    logic                 busy_rx;

    modport master (
        output enable_rx,
        output msg_in_rx,
        input  msg_out_rx,
        input  valid_rx,
        input  frame_err_rx,
        input  busy_rx
    );

    modport slave (
        input  enable_rx,
        input  msg_in_rx,
        output msg_out_rx,
        output valid_rx,
        output frame_err_rx,
        output busy_rx
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_deser.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_deser
// Brief    : UART frame receiver, MSB-first codeword, mid-bit sampling.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_deser #(
    parameter int MSG_WIDTH  = 15,
    parameter int BIT_CYCLES = 1
) (
    input  wire logic          clk_rx,
    input  wire logic          rst_n_rx,
    uart_rx_deser_if.slave     rx
);

    localparam int H  = (BIT_CYCLES - 1) / 2;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(MSG_WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MID  = (H > 0) ? CW'(H - 1) : '0;
    localparam logic [BW-1:0] BIT_LAST = BW'(MSG_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [MSG_WIDTH-1:0] shift_q, shift_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk_rx or negedge rst_n_rx) begin
        if (!rst_n_rx) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // cnt_q counts edges since the last sample point (or detection), minus one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        msg_d   = msg_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (!rx.enable_rx) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx.msg_in_rx) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = (H == 0) ? DATA : START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        state_d = rx.msg_in_rx ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {shift_q[MSG_WIDTH-2:0], rx.msg_in_rx};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx.msg_in_rx) begin
                            msg_d   = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // a held-low line must not be taken as a stream of start bits
                    if (rx.msg_in_rx) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
    end

    assign rx.msg_out_rx   = msg_q;
    assign rx.valid_rx     = valid_q;
    assign rx.frame_err_rx = ferr_q;
    assign rx.busy_rx      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_deser
// Brief    : Self-checking bench for uart_rx_deser at 1 and 4 clocks per bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_deser;

    localparam int W = 15;

    logic clk_rx = 1'b0;
    logic rst_n_rx;
    always #5 clk_rx = ~clk_rx;

    uart_rx_deser_if #(.MSG_WIDTH(W)) if1 ();
    uart_rx_deser_if #(.MSG_WIDTH(W)) if4 ();

    uart_rx_deser #(.MSG_WIDTH(W), .BIT_CYCLES(1)) u_dut1 (
        .clk_rx   (clk_rx),
        .rst_n_rx (rst_n_rx),
        .rx       (if1)
    );

    uart_rx_deser #(.MSG_WIDTH(W), .BIT_CYCLES(4)) u_dut4 (
        .clk_rx   (clk_rx),
        .rst_n_rx (rst_n_rx),
        .rx       (if4)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int           v1_cyc[$];
    logic [W-1:0] v1_dat[$];
    int           f1_cyc[$];
    int           v4_cyc[$];
    logic [W-1:0] v4_dat[$];
    int           f4_cyc[$];
    bit           busy1_hist [0:8191];
    logic [W-1:0] last1;
    logic [W-1:0] last4;

    always @(posedge clk_rx) cyc <= cyc + 1;

    // event log: cycle index is the number of the rising edge just passed
    always @(negedge clk_rx) begin
        if (if1.valid_rx) begin
            v1_cyc.push_back(cyc);
            v1_dat.push_back(if1.msg_out_rx);
        end
        if (if1.frame_err_rx) f1_cyc.push_back(cyc);
        if (if4.valid_rx) begin
            v4_cyc.push_back(cyc);
            v4_dat.push_back(if4.msg_out_rx);
        end
        if (if4.frame_err_rx) f4_cyc.push_back(cyc);
        if (cyc < 8192) busy1_hist[cyc] <= if1.busy_rx;
    end

    // reference timing: stop-bit sample edge relative to the transmitter load edge
    function automatic int exp_done(input int n0, input int bc);
        return n0 + 1 + (bc - 1) / 2 + (W + 1) * bc;
    endfunction

    task automatic step();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 1) if1.msg_in_rx = v;
        else          if4.msg_in_rx = v;
    endtask

    task automatic drive_bit(input int sel, input logic v, input int bc);
        set_line(sel, v);
        repeat (bc) step();
    endtask

    task automatic tx_frame(input int sel, input logic [W-1:0] d, input int bc,
                            input int stop_low, output int n0);
        n0 = cyc;
        drive_bit(sel, 1'b0, bc);
        for (int i = W - 1; i >= 0; i--) drive_bit(sel, d[i], bc);
        repeat (stop_low) drive_bit(sel, 1'b0, bc);
        drive_bit(sel, 1'b1, bc);
    endtask

    task automatic clear_mon();
        v1_cyc.delete(); v1_dat.delete(); f1_cyc.delete();
        v4_cyc.delete(); v4_dat.delete(); f4_cyc.delete();
    endtask

    task automatic check_one_frame1(input string name, input int n0, input logic [W-1:0] d);
        checks++;
        if (v1_cyc.size() !== 1) begin
            failures++;
            $display("FAIL %s valid_count: got %0d expected 1", name, v1_cyc.size());
        end else begin
            checks++;
            if (v1_cyc[0] !== exp_done(n0, 1)) begin
                failures++;
                $display("FAIL %s valid_cycle: got %0d expected %0d", name, v1_cyc[0], exp_done(n0, 1));
            end
            checks++;
            if (v1_dat[0] !== d) begin
                failures++;
                $display("FAIL %s data: got %h expected %h", name, v1_dat[0], d);
            end
        end
        checks++;
        if (f1_cyc.size() !== 0) begin
            failures++;
            $display("FAIL %s frame_err_count: got %0d expected 0", name, f1_cyc.size());
        end
    endtask

    task automatic test_reset();
        rst_n_rx      = 1'b0;
        if1.enable_rx = 1'b1;
        if1.msg_in_rx = 1'b1;
        if4.enable_rx = 1'b1;
        if4.msg_in_rx = 1'b1;
        repeat (3) step();
        checks++;
        if ({if1.msg_out_rx, if1.valid_rx, if1.frame_err_rx, if1.busy_rx} !== '0) begin
            failures++;
            $display("FAIL reset_dut1: got %h/%b/%b/%b expected 0/0/0/0",
                     if1.msg_out_rx, if1.valid_rx, if1.frame_err_rx, if1.busy_rx);
        end
        checks++;
        if ({if4.msg_out_rx, if4.valid_rx, if4.frame_err_rx, if4.busy_rx} !== '0) begin
            failures++;
            $display("FAIL reset_dut4: got %h/%b/%b/%b expected 0/0/0/0",
                     if4.msg_out_rx, if4.valid_rx, if4.frame_err_rx, if4.busy_rx);
        end
        rst_n_rx = 1'b1;
        repeat (2) step();
        checks++;
        if (if1.busy_rx !== 1'b0 || if1.valid_rx !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", if1.busy_rx, if1.valid_rx);
        end
        last1 = '0;
        last4 = '0;
    endtask

    task automatic test_single();
        int n0;
        logic [W-1:0] d;
        d = 15'h5A3C;
        clear_mon();
        tx_frame(1, d, 1, 0, n0);
        repeat (3) step();
        check_one_frame1("single", n0, d);
        for (int k = 0; k <= 17; k++) begin
            checks++;
            if (busy1_hist[n0 + k] !== (k >= 1 && k <= 16)) begin
                failures++;
                $display("FAIL single_busy[E%0d]: got %b expected %b",
                         k, busy1_hist[n0 + k], (k >= 1 && k <= 16));
            end
        end
        checks++;
        if (if1.msg_out_rx !== d) begin
            failures++;
            $display("FAIL single_hold: got %h expected %h", if1.msg_out_rx, d);
        end
        last1 = d;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] dl[6];
        int n0s[6];
        dl[0] = 15'h7FFF;
        dl[1] = 15'h0001;
        for (int i = 2; i < 6; i++) dl[i] = W'($urandom);
        clear_mon();
        for (int i = 0; i < 6; i++) tx_frame(1, dl[i], 1, 0, n0s[i]);
        repeat (3) step();
        checks++;
        if (v1_cyc.size() !== 6) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 6", v1_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (v1_cyc[i] !== exp_done(n0s[i], 1) || v1_dat[i] !== dl[i]) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                             i, v1_cyc[i], v1_dat[i], exp_done(n0s[i], 1), dl[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (v1_cyc[i] - v1_cyc[i-1] !== (W + 2)) begin
                        failures++;
                        $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                                 i, v1_cyc[i] - v1_cyc[i-1], W + 2);
                    end
                end
            end
        end
        checks++;
        if (f1_cyc.size() !== 0) begin
            failures++;
            $display("FAIL b2b_frame_err: got %0d expected 0", f1_cyc.size());
        end
        last1 = dl[5];
    endtask

    task automatic test_frame_err();
        int n0;
        logic [W-1:0] d;
        clear_mon();
        tx_frame(1, 15'h1234, 1, 5, n0);
        repeat (2) step();
        checks++;
        if (f1_cyc.size() !== 1) begin
            failures++;
            $display("FAIL ferr_count: got %0d expected 1", f1_cyc.size());
        end else begin
            checks++;
            if (f1_cyc[0] !== exp_done(n0, 1)) begin
                failures++;
                $display("FAIL ferr_cycle: got %0d expected %0d", f1_cyc[0], exp_done(n0, 1));
            end
        end
        checks++;
        if (v1_cyc.size() !== 0) begin
            failures++;
            $display("FAIL ferr_no_valid: got %0d expected 0", v1_cyc.size());
        end
        checks++;
        if (if1.msg_out_rx !== last1) begin
            failures++;
            $display("FAIL ferr_msg_hold: got %h expected %h", if1.msg_out_rx, last1);
        end
        checks++;
        if (busy1_hist[n0 + 19] !== 1'b0) begin
            failures++;
            $display("FAIL ferr_wait_busy: got %b expected 0", busy1_hist[n0 + 19]);
        end
        d = 15'h0ABC;
        clear_mon();
        tx_frame(1, d, 1, 0, n0);
        repeat (3) step();
        check_one_frame1("ferr_recover", n0, d);
        last1 = d;
    endtask

    task automatic test_glitch();
        int n0;
        logic [W-1:0] d;
        clear_mon();
        set_line(4, 1'b0);
        step();
        set_line(4, 1'b1);
        repeat (12) step();
        checks++;
        if (v4_cyc.size() !== 0 || f4_cyc.size() !== 0 || if4.busy_rx !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: got valid=%0d ferr=%0d busy=%b expected 0/0/0",
                     v4_cyc.size(), f4_cyc.size(), if4.busy_rx);
        end
        for (int j = 0; j < 2; j++) begin
            d = (j == 0) ? 15'h2AAA : W'($urandom);
            clear_mon();
            tx_frame(4, d, 4, 0, n0);
            repeat (3) step();
            checks++;
            if (v4_cyc.size() !== 1) begin
                failures++;
                $display("FAIL bc4_count%0d: got %0d expected 1", j, v4_cyc.size());
            end else begin
                checks++;
                if (v4_cyc[0] !== exp_done(n0, 4) || v4_dat[0] !== d) begin
                    failures++;
                    $display("FAIL bc4_frame%0d: got cyc=%0d data=%h expected cyc=%0d data=%h",
                             j, v4_cyc[0], v4_dat[0], exp_done(n0, 4), d);
                end
            end
            checks++;
            if (f4_cyc.size() !== 0) begin
                failures++;
                $display("FAIL bc4_ferr%0d: got %0d expected 0", j, f4_cyc.size());
            end
            last4 = d;
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [W-1:0] d;
        d = W'($urandom);
        clear_mon();
        drive_bit(1, 1'b0, 1);
        for (int i = W - 1; i > W - 8; i--) drive_bit(1, d[i], 1);
        set_line(1, d[W-8]);
        #2;
        checks++;
        if (if1.busy_rx !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before: got %b expected 1", if1.busy_rx);
        end
        rst_n_rx = 1'b0;
        #1;
        checks++;
        if ({if1.msg_out_rx, if1.valid_rx, if1.frame_err_rx, if1.busy_rx} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear: got %h/%b/%b/%b expected 0/0/0/0",
                     if1.msg_out_rx, if1.valid_rx, if1.frame_err_rx, if1.busy_rx);
        end
        set_line(1, 1'b1);
        repeat (2) step();
        rst_n_rx = 1'b1;
        repeat (20) step();
        checks++;
        if (v1_cyc.size() !== 0 || f1_cyc.size() !== 0) begin
            failures++;
            $display("FAIL rstmid_no_pulse: got valid=%0d ferr=%0d expected 0/0",
                     v1_cyc.size(), f1_cyc.size());
        end
        d = 15'h4321;
        clear_mon();
        tx_frame(1, d, 1, 0, n0);
        repeat (3) step();
        check_one_frame1("rstmid_next", n0, d);
        last1 = d;
        last4 = '0;
    endtask

    task automatic test_enable_abort();
        int n0;
        logic [W-1:0] d;
        d = W'($urandom);
        clear_mon();
        drive_bit(1, 1'b0, 1);
        for (int i = W - 1; i > W - 4; i--) drive_bit(1, d[i], 1);
        checks++;
        if (if1.busy_rx !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got %b expected 1", if1.busy_rx);
        end
        if1.enable_rx = 1'b0;
        set_line(1, 1'b1);
        step();
        checks++;
        if (if1.busy_rx !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy_fall: got %b expected 0", if1.busy_rx);
        end
        step();
        if1.enable_rx = 1'b1;
        repeat (20) step();
        checks++;
        if (v1_cyc.size() !== 0 || f1_cyc.size() !== 0 || if1.msg_out_rx !== last1) begin
            failures++;
            $display("FAIL abort_quiet: got valid=%0d ferr=%0d msg=%h expected 0/0/%h",
                     v1_cyc.size(), f1_cyc.size(), if1.msg_out_rx, last1);
        end
        d = W'($urandom);
        clear_mon();
        tx_frame(1, d, 1, 0, n0);
        repeat (3) step();
        check_one_frame1("abort_next", n0, d);
        last1 = d;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_enable_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Serial receiver on the link driven by the Hamming-code UART transmitter.
- Detects the start bit, deserialises a MSG_WIDTH-bit codeword sent MSB-first, checks the stop bit, and presents the parallel word with a one-cycle valid strobe.
- Its output feeds the Hamming decoder.
- Line format: idle 1, start 0, MSG_WIDTH data bits MSB-first, stop 1.

Parameters:
- MSG_WIDTH, 15, codeword width in bits.
- BIT_CYCLES, 1, clocks per serial bit; must be >= 1. A value of 1 matches the transmitter, which shifts one bit per clock.

Ports:
- clk_rx  input  1  clock; all state changes on the rising edge.
- rst_n_rx  input  1  reset, asynchronous, active-low.
- enable_rx  input  1  receive enable; low forces IDLE and aborts any frame in progress.
- msg_in_rx  input  1  serial line from transmitter; idle high.
- msg_out_rx  output  MSG_WIDTH  last correctly framed codeword, first received bit at bit MSG_WIDTH-1.
- valid_rx  output  1  one-cycle pulse: msg_out_rx was updated.
- frame_err_rx  output  1  one-cycle pulse: stop bit was sampled 0.
- busy_rx  output  1  high while in START, DATA or STOP.

Behaviour:
- Clock and reset: one clock, clk_rx. Reset rst_n_rx is asynchronous and active-low.
- Reset values: state IDLE, msg_out_rx=0, valid_rx=0, frame_err_rx=0, busy_rx=0, shift register=0, bit counter=0, cycle counter=0.
- Reset mid-frame clears everything immediately. No pulse is emitted for the aborted frame.
- All outputs are registered. msg_in_rx is sampled directly, with no synchroniser, because it is a same-clock link.
- H = (BIT_CYCLES-1)/2, using integer division, is the mid-bit sample offset. The detection edge is cycle 0 of the start bit.
- IDLE:
  - When enable_rx=1 and msg_in_rx=0, clear the cycle counter and go to START.
  - If H=0, the start bit is confirmed on this same edge and the state goes straight to DATA.
- START:
  - At cycle H, resample the line.
  - If the line is 0, go to DATA.
  - If the line is 1, it is a glitch: go to IDLE with no pulse.
- DATA:
  - Data bit k (k=0..MSG_WIDTH-1) is sampled at cycle H+(k+1)*BIT_CYCLES after detection.
  - Each sample is shifted in at the LSB, so the first bit received ends in the MSB.
  - After MSG_WIDTH bits, go to STOP.
- STOP: the stop bit is sampled at cycle H+(MSG_WIDTH+1)*BIT_CYCLES.
  - If the line is 1, load msg_out_rx from the shift register, set valid_rx=1 for exactly one cycle, and go to IDLE.
  - If the line is 0, set frame_err_rx=1 for one cycle, leave msg_out_rx unchanged, and go to WAIT_HIGH.
- WAIT_HIGH: stay until msg_in_rx=1, then go to IDLE. This prevents a held-low line or break from being decoded as frames. busy_rx=0 in this state.
- valid_rx and frame_err_rx are never high in the same cycle. msg_out_rx holds its value between frames.
- Latency with BIT_CYCLES=1:
  - The transmitter loads on edge E0 and the start bit is visible after E0.
  - The receiver detects at E1, samples data at E2..E16 and the stop bit at E17.
  - valid_rx is high in the cycle following E17.
- Back-to-back frames:
  - A new start bit sampled on the edge immediately after the stop-sample edge is accepted, because the state is already IDLE.
  - The minimum frame period is (MSG_WIDTH+2)*BIT_CYCLES clocks, which is 17 at the default parameters.
- enable_rx=0 in any state forces IDLE (from WAIT_HIGH as well) and clears busy_rx. No valid_rx or frame_err_rx pulse is produced for an aborted frame.
- Counter widths: the cycle counter must hold BIT_CYCLES-1, and the bit counter must hold MSG_WIDTH. No wrap-around is allowed within a frame.

Test Plan:
- Single frame, BIT_CYCLES=1: transmitter model sends 15'h5A3C with enable on E0 -> busy_rx high from after E1 until E17. valid_rx is high only in the cycle after E17, with msg_out_rx=15'h5A3C. frame_err_rx stays 0.
- Back-to-back frames: 15'h7FFF then 15'h0001 with transmitter enable every 17 clocks -> two valid_rx pulses exactly 17 cycles apart, carrying 15'h7FFF then 15'h0001. No frame_err_rx.
- Framing error: start, data 15'h1234, then the line is held 0 for 5 bit times before returning to 1 -> one frame_err_rx pulse and no valid_rx. msg_out_rx keeps its previous value. Nothing further is received until the line is 1; a following frame 15'h0ABC is then received correctly.
- Glitch rejection, BIT_CYCLES=4 (H=1): line low for 1 clock, then high -> return to IDLE with no valid_rx or frame_err_rx pulse. A full frame 15'h2AAA at 4 clocks per bit then yields valid_rx with msg_out_rx=15'h2AAA.
- Reset mid-frame: assert rst_n_rx during data bit 7, asynchronously between edges -> all outputs 0 immediately. After release, the next frame 15'h4321 is received with valid_rx.
- Enable abort: drop enable_rx during data bit 3 for 2 cycles -> busy_rx falls on the next edge, with no valid_rx or frame_err_rx. The next full frame is received normally.
